// File: rtl/gpr_pkg.sv
// Shared types and constants for the multi-port GPR file.
// ABI register names are provided for readable stimulus and debug code.
package gpr_pkg;

  localparam int NREG_DFLT = 32;
  localparam int XLEN_DFLT = 64;
  localparam int REG_AW    = $clog2(NREG_DFLT);

  typedef logic [REG_AW-1:0]    reg_addr_t;
  typedef logic [XLEN_DFLT-1:0] xlen_t;

  localparam reg_addr_t ZERO = 5'd0;
  localparam reg_addr_t RA   = 5'd1;
  localparam reg_addr_t SP   = 5'd2;
  localparam reg_addr_t GP   = 5'd3;
  localparam reg_addr_t TP   = 5'd4;
  localparam reg_addr_t T0   = 5'd5;
  localparam reg_addr_t T1   = 5'd6;
  localparam reg_addr_t T2   = 5'd7;
  localparam reg_addr_t S0   = 5'd8;
  localparam reg_addr_t S1   = 5'd9;
  localparam reg_addr_t A0   = 5'd10;
  localparam reg_addr_t A1   = 5'd11;
  localparam reg_addr_t A2   = 5'd12;

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/gpr_scoreboard.sv
// Busy-bit scoreboard: issue reserves a destination, writeback releases it.
// A reserve and a release of the same register in one cycle leaves it busy.
module gpr_scoreboard
  import gpr_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          rsv_en_i,
  input  logic [$clog2(NREG)-1:0]       rsv_addr_i,
  input  logic [NWR-1:0]                wr_en_i,
  input  logic [NWR*$clog2(NREG)-1:0]   wr_addr_i,
  output logic [NREG-1:0]               busy_o
);

  localparam int AW = $clog2(NREG);

  logic [NREG-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en_i[j]) busy_d[wr_addr_i[j*AW +: AW]] = 1'b0;
    end
    // set is applied last so a new producer supersedes the one retiring
    if (rsv_en_i) busy_d[rsv_addr_i] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/gpr_file_mp.sv
// Multi-port integer register file with write-to-read bypass, hardwired zero
// register option, debug read port and an integrated busy scoreboard.
module gpr_file_mp
  import gpr_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NRD*$clog2(NREG)-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0]           rd_data,
  output logic [NRD-1:0]                rd_busy,
  input  logic [NWR-1:0]                wr_en,
  input  logic [NWR*$clog2(NREG)-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0]           wr_data,
  input  logic                          rsv_en,
  input  logic [$clog2(NREG)-1:0]       rsv_addr,
  input  logic [$clog2(NREG)-1:0]       dbg_addr,
  output logic [XLEN-1:0]               dbg_data
);

  localparam int AW = $clog2(NREG);

  if (!is_pow2(NREG)) begin : g_bad_nreg
    $error("gpr_file_mp: NREG must be a power of 2 and at least 2");
  end
  if (NWR < 1 || NWR > 2) begin : g_bad_nwr
    $error("gpr_file_mp: NWR must be 1 or 2");
  end

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy;

  gpr_scoreboard #(
    .NREG     (NREG),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clock      (clock),
    .reset      (reset),
    .rsv_en_i   (rsv_en),
    .rsv_addr_i (rsv_addr),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .busy_o     (busy)
  );

  // later ports overwrite earlier ones, so port 1 wins an address conflict
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && !(ZERO_REG != 0 && wr_addr[j*AW +: AW] == '0))
          regs_q[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_data[i*XLEN +: XLEN] = regs_q[rd_addr[i*AW +: AW]];
      rd_busy[i]              = busy[rd_addr[i*AW +: AW]];
      if (BYPASS != 0) begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j] && wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])
            rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
        end
      end
      if (ZERO_REG != 0 && rd_addr[i*AW +: AW] == '0) rd_data[i*XLEN +: XLEN] = '0;
    end
  end

  assign dbg_data = (ZERO_REG != 0 && dbg_addr == '0) ? '0 : regs_q[dbg_addr];

endmodule

// File: tb/tb_gpr_file_mp.sv
// Directed bench: dual-write bypassing instance plus a single-write,
// non-bypassing instance sharing the same stimulus.
module tb_gpr_file_mp;
  import gpr_pkg::*;

  logic         clock;
  logic         reset;
  logic [9:0]   rd_addr;
  logic [1:0]   wr_en;
  logic [9:0]   wr_addr;
  logic [127:0] wr_data;
  logic         rsv_en;
  logic [4:0]   rsv_addr;
  logic [4:0]   dbg_addr;

  logic [127:0] rd_data_b;
  logic [1:0]   rd_busy_b;
  logic [63:0]  dbg_data_b;
  logic [127:0] rd_data_n;
  logic [1:0]   rd_busy_n;
  logic [63:0]  dbg_data_n;

  int checks = 0;
  int errors = 0;

  gpr_file_mp #(.XLEN(64), .NREG(32), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1)) dut_byp (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data_b)
  );

  gpr_file_mp #(.XLEN(64), .NREG(32), .NRD(2), .NWR(1), .BYPASS(0), .ZERO_REG(1)) dut_nob (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_en(wr_en[0:0]), .wr_addr(wr_addr[4:0]), .wr_data(wr_data[63:0]), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .dbg_addr(dbg_addr), .dbg_data(dbg_data_n)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wr_en    = 2'b00;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
  endtask

  localparam logic [63:0] DEAD = 64'hDEAD_BEEF_0000_0001;

  initial begin
    reset = 1'b0;
    rd_addr = '0;
    dbg_addr = '0;
    idle();
    tick();
    tick();
    reset = 1'b1;

    // fill a few registers and reserve one, then reset over it
    for (int i = 1; i <= 4; i++) begin
      wr_en = 2'b01;
      wr_addr[4:0] = 5'(i);
      wr_data[63:0] = 64'(i) * 64'h111;
      rsv_en = 1'b1;
      rsv_addr = S1;
      tick();
    end
    idle();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      chk($sformatf("rst_dbg%0d", i), dbg_data_b, 64'h0);
    end
    rd_addr = {S1, S1};
    #1;
    chk("rst_busy_byp", {62'h0, rd_busy_b}, 64'h0);
    chk("rst_busy_nob", {62'h0, rd_busy_n}, 64'h0);
    rd_addr = {RA, RA};
    #1;
    chk("rst_rd0", rd_data_b[63:0], 64'h0);
    chk("rst_rd1", rd_data_b[127:64], 64'h0);

    // same-cycle bypass vs stored-only read
    wr_en = 2'b01;
    wr_addr[4:0] = T0;
    wr_data[63:0] = DEAD;
    rd_addr = {ZERO, T0};
    dbg_addr = T0;
    #1;
    chk("byp_rd0", rd_data_b[63:0], DEAD);
    chk("byp_dbg_before", dbg_data_b, 64'h0);
    chk("nob_rd0_before", rd_data_n[63:0], 64'h0);
    tick();
    idle();
    #1;
    chk("byp_dbg_after", dbg_data_b, DEAD);
    chk("nob_rd0_after", rd_data_n[63:0], DEAD);
    chk("byp_rd0_after", rd_data_b[63:0], DEAD);

    // hardwired zero register
    wr_en = 2'b01;
    wr_addr[4:0] = ZERO;
    wr_data[63:0] = 64'hFFFF;
    rsv_en = 1'b1;
    rsv_addr = ZERO;
    rd_addr = {ZERO, ZERO};
    dbg_addr = ZERO;
    #1;
    chk("zero_byp_rd0", rd_data_b[63:0], 64'h0);
    chk("zero_byp_rd1", rd_data_b[127:64], 64'h0);
    tick();
    idle();
    #1;
    chk("zero_rd0", rd_data_b[63:0], 64'h0);
    chk("zero_rd1", rd_data_b[127:64], 64'h0);
    chk("zero_dbg", dbg_data_b, 64'h0);
    chk("zero_busy", {62'h0, rd_busy_b}, 64'h0);

    // dual-write conflict: port 1 wins
    wr_en = 2'b11;
    wr_addr = {T2, T2};
    wr_data = {64'h22, 64'h11};
    rd_addr = {T2, T2};
    dbg_addr = T2;
    #1;
    chk("dual_byp_rd0", rd_data_b[63:0], 64'h22);
    chk("dual_byp_rd1", rd_data_b[127:64], 64'h22);
    tick();
    idle();
    #1;
    chk("dual_rd0", rd_data_b[63:0], 64'h22);
    chk("dual_dbg", dbg_data_b, 64'h22);

    // scoreboard reserve / release / set-wins
    rsv_en = 1'b1;
    rsv_addr = A0;
    rd_addr = {A0, ZERO};
    dbg_addr = A0;
    #1;
    chk("sb_busy_no_fwd", {63'h0, rd_busy_b[1]}, 64'h0);
    tick();
    idle();
    #1;
    chk("sb_rsv_byp", {63'h0, rd_busy_b[1]}, 64'h1);
    chk("sb_rsv_nob", {63'h0, rd_busy_n[1]}, 64'h1);
    chk("sb_rsv_port0", {63'h0, rd_busy_b[0]}, 64'h0);
    wr_en = 2'b01;
    wr_addr[4:0] = A0;
    wr_data[63:0] = 64'hA;
    #1;
    chk("sb_clr_no_fwd", {63'h0, rd_busy_b[1]}, 64'h1);
    tick();
    idle();
    #1;
    chk("sb_clr", {63'h0, rd_busy_b[1]}, 64'h0);
    chk("sb_clr_data", dbg_data_b, 64'hA);
    wr_en = 2'b01;
    wr_addr[4:0] = A0;
    wr_data[63:0] = 64'hBB;
    rsv_en = 1'b1;
    rsv_addr = A0;
    tick();
    idle();
    #1;
    chk("sb_setwins_byp", {63'h0, rd_busy_b[1]}, 64'h1);
    chk("sb_setwins_nob", {63'h0, rd_busy_n[1]}, 64'h1);
    chk("sb_setwins_data", dbg_data_b, 64'hBB);
    // a release through port 1 also clears
    wr_en = 2'b10;
    wr_addr = {A0, ZERO};
    wr_data = {64'hCC, 64'h0};
    tick();
    idle();
    #1;
    chk("sb_clr_port1", {63'h0, rd_busy_b[1]}, 64'h0);
    chk("sb_clr_port1_data", dbg_data_b, 64'hCC);
    chk("sb_nob_still_busy", {63'h0, rd_busy_n[1]}, 64'h1);
    // release of a non-busy register stays clear
    wr_en = 2'b01;
    wr_addr[4:0] = A2;
    wr_data[63:0] = 64'h7;
    rd_addr = {A2, A2};
    tick();
    idle();
    #1;
    chk("sb_nonbusy_write", {62'h0, rd_busy_b}, 64'h0);

    // reset wins over a same-cycle reserve and write
    reset = 1'b0;
    wr_en = 2'b01;
    wr_addr[4:0] = GP;
    wr_data[63:0] = 64'h55;
    rsv_en = 1'b1;
    rsv_addr = GP;
    tick();
    idle();
    reset = 1'b1;
    rd_addr = {GP, GP};
    dbg_addr = GP;
    #1;
    chk("mrst_dbg", dbg_data_b, 64'h0);
    chk("mrst_busy", {62'h0, rd_busy_b}, 64'h0);
    chk("mrst_nob_dbg", dbg_data_n, 64'h0);
    dbg_addr = A0;
    rd_addr = {A0, A0};
    #1;
    chk("mrst_a0_dbg", dbg_data_b, 64'h0);
    chk("mrst_a0_busy_nob", {62'h0, rd_busy_n}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
